// File: rtl/kamus_lsu.sv
// MEM-stage load/store unit: turns one RV32I load/store into a req/gnt/rvalid
// transaction on the L1D port and returns aligned, extended load data to WB.
module kamus_lsu #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned BUS_TIMEOUT = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  lsu_valid_i,
    input  logic                  lsu_we_i,
    input  logic [2:0]            lsu_funct3_i,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [31:0]           lsu_wdata_i,
    input  logic [4:0]            lsu_rd_addr_i,
    output logic                  lsu_stall_o,
    output logic                  lsu_misaligned_o,
    output logic                  lsu_bus_err_o,
    output logic                  wb_valid_o,
    output logic [4:0]            wb_rd_addr_o,
    output logic [31:0]           wb_data_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [31:0]           data_wdata_o,
    input  logic                  data_rvalid_i,
    input  logic [31:0]           data_rdata_i
);
    localparam int unsigned CNT_W   = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;
    localparam int unsigned TO_LAST = (BUS_TIMEOUT == 0) ? 0 : BUS_TIMEOUT - 1;

    typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         funct3_q;
    logic [1:0]         off_q;
    logic [4:0]         rd_q;

    logic               misaligned;
    logic [3:0]         be_n;
    logic [31:0]        wdata_n;
    logic [31:0]        shifted;
    logic [31:0]        load_n;

    always_comb begin
        misaligned = 1'b0;
        if (lsu_funct3_i[1]) begin
            misaligned = |lsu_addr_i[1:0];
        end else if (lsu_funct3_i[0]) begin
            misaligned = lsu_addr_i[0];
        end
    end

    always_comb begin
        be_n    = 4'b1111;
        wdata_n = lsu_wdata_i;
        case (lsu_funct3_i[1:0])
            2'b00: begin
                be_n    = 4'b0001 << lsu_addr_i[1:0];
                wdata_n = {4{lsu_wdata_i[7:0]}};
            end
            2'b01: begin
                be_n    = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{lsu_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted = data_rdata_i >> {off_q, 3'b000};
        load_n  = data_rdata_i;
        case (funct3_q[1:0])
            2'b00:   load_n = {{24{~funct3_q[2] & shifted[7]}}, shifted[7:0]};
            2'b01:   load_n = {{16{~funct3_q[2] & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

    // Gated by reset so the whole output set reads zero while reset is held.
    assign lsu_stall_o = ~rst_i & (((state_q == StIdle) & lsu_valid_i & ~misaligned)
                                   | (state_q == StReq) | (state_q == StResp));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= StIdle;
            cnt_q            <= '0;
            funct3_q         <= '0;
            off_q            <= '0;
            rd_q             <= '0;
            lsu_misaligned_o <= 1'b0;
            lsu_bus_err_o    <= 1'b0;
            wb_valid_o       <= 1'b0;
            wb_rd_addr_o     <= '0;
            wb_data_o        <= '0;
            data_req_o       <= 1'b0;
            data_addr_o      <= '0;
            data_we_o        <= 1'b0;
            data_be_o        <= '0;
            data_wdata_o     <= '0;
        end else begin
            lsu_misaligned_o <= 1'b0;
            lsu_bus_err_o    <= 1'b0;
            wb_valid_o       <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (lsu_valid_i) begin
                        if (misaligned) begin
                            lsu_misaligned_o <= 1'b1;
                        end else begin
                            data_req_o   <= 1'b1;
                            data_addr_o  <= {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
                            data_we_o    <= lsu_we_i;
                            data_be_o    <= be_n;
                            data_wdata_o <= wdata_n;
                            funct3_q     <= lsu_funct3_i;
                            off_q        <= lsu_addr_i[1:0];
                            rd_q         <= lsu_rd_addr_i;
                            state_q      <= StReq;
                        end
                    end
                end
                StReq: begin
                    if (data_gnt_i) begin
                        data_req_o <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= StResp;
                    end
                end
                StResp: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (data_rvalid_i) begin
                        if (!data_we_o) begin
                            wb_valid_o   <= 1'b1;
                            wb_data_o    <= load_n;
                            wb_rd_addr_o <= rd_q;
                        end
                        state_q <= StDone;
                    end else if ((BUS_TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST))) begin
                        lsu_bus_err_o <= 1'b1;
                        state_q       <= StDone;
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_kamus_lsu.sv
// Randomized bench for kamus_lsu: drives the MEM-stage inputs and a responsive bus,
// and compares every observable against an arithmetic model of the access rules.
module tb_kamus_lsu;
    localparam int unsigned AW = 32;
    localparam int unsigned TO = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          lsu_valid_i = 1'b0;
    logic          lsu_we_i = 1'b0;
    logic [2:0]    lsu_funct3_i = '0;
    logic [AW-1:0] lsu_addr_i = '0;
    logic [31:0]   lsu_wdata_i = '0;
    logic [4:0]    lsu_rd_addr_i = '0;
    logic          lsu_stall_o;
    logic          lsu_misaligned_o;
    logic          lsu_bus_err_o;
    logic          wb_valid_o;
    logic [4:0]    wb_rd_addr_o;
    logic [31:0]   wb_data_o;
    logic          data_req_o;
    logic          data_gnt_i = 1'b0;
    logic [AW-1:0] data_addr_o;
    logic          data_we_o;
    logic [3:0]    data_be_o;
    logic [31:0]   data_wdata_o;
    logic          data_rvalid_i = 1'b0;
    logic [31:0]   data_rdata_i = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    kamus_lsu #(.ADDR_WIDTH(AW), .BUS_TIMEOUT(TO)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .lsu_valid_i      (lsu_valid_i),
        .lsu_we_i         (lsu_we_i),
        .lsu_funct3_i     (lsu_funct3_i),
        .lsu_addr_i       (lsu_addr_i),
        .lsu_wdata_i      (lsu_wdata_i),
        .lsu_rd_addr_i    (lsu_rd_addr_i),
        .lsu_stall_o      (lsu_stall_o),
        .lsu_misaligned_o (lsu_misaligned_o),
        .lsu_bus_err_o    (lsu_bus_err_o),
        .wb_valid_o       (wb_valid_o),
        .wb_rd_addr_o     (wb_rd_addr_o),
        .wb_data_o        (wb_data_o),
        .data_req_o       (data_req_o),
        .data_gnt_i       (data_gnt_i),
        .data_addr_o      (data_addr_o),
        .data_we_o        (data_we_o),
        .data_be_o        (data_be_o),
        .data_wdata_o     (data_wdata_o),
        .data_rvalid_i    (data_rvalid_i),
        .data_rdata_i     (data_rdata_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference rules, written as plain arithmetic on size / offset.
    function automatic int size_bytes(input logic [2:0] f3);
        return (f3[1]) ? 4 : (f3[0] ? 2 : 1);
    endfunction

    function automatic logic is_misal(input logic [2:0] f3, input logic [31:0] a);
        return (a % size_bytes(f3)) != 0;
    endfunction

    function automatic logic [31:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int n = size_bytes(f3);
        return ((32'd1 << n) - 1) << (a % 4);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        int n = size_bytes(f3);
        if (n == 1) return (d % 256) * 32'h0101_0101;
        if (n == 2) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        int n = size_bytes(f3);
        logic [31:0] v, lim;
        if (n == 4) return rd;
        v   = (rd >> (8 * (a % 4))) % (32'd1 << (8 * n));
        lim = 32'd1 << (8 * n - 1);
        if (!f3[2] && v >= lim) v = v - 2 * lim;
        return v;
    endfunction

    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, input int gd,
                         input int rvd, input logic [31:0] rdata);
        logic mis, tmo;
        mis = is_misal(f3, addr);
        tmo = (rvd >= TO);
        @(negedge clk_i);
        lsu_valid_i = 1'b1; lsu_we_i = we; lsu_funct3_i = f3;
        lsu_addr_i = addr; lsu_wdata_i = wd; lsu_rd_addr_i = rd;
        #1 check("stall_idle", lsu_stall_o, !mis);
        if (mis) begin
            @(negedge clk_i);
            lsu_valid_i = 1'b0;
            #1;
            check("misaligned", lsu_misaligned_o, 1);
            check("mis_no_req", data_req_o, 0);
            check("mis_stall", lsu_stall_o, 0);
            @(negedge clk_i);
            check("mis_pulse", lsu_misaligned_o, 0);
            check("mis_no_req2", data_req_o, 0);
            return;
        end
        for (int k = 0; k <= gd; k++) begin
            @(negedge clk_i);
            check("req", data_req_o, 1);
            check("req_stall", lsu_stall_o, 1);
            check("addr", data_addr_o, addr & 32'hFFFF_FFFC);
            check("we", data_we_o, we);
            check("be", data_be_o, m_be(f3, addr));
            if (we) check("wdata", data_wdata_o, m_wdata(f3, wd));
            data_gnt_i = (k == gd);
        end
        for (int j = 0; j < TO; j++) begin
            @(negedge clk_i);
            data_gnt_i = 1'b0;
            check("resp_req", data_req_o, 0);
            check("resp_stall", lsu_stall_o, 1);
            if (j == rvd) begin
                data_rvalid_i = 1'b1;
                data_rdata_i  = rdata;
                break;
            end
        end
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        check("done_stall", lsu_stall_o, 0);
        check("wb_valid", wb_valid_o, !we && !tmo);
        check("bus_err", lsu_bus_err_o, tmo);
        if (!we && !tmo) begin
            check("wb_data", wb_data_o, m_load(f3, addr, rdata));
            check("wb_rd", wb_rd_addr_o, rd);
        end
        lsu_valid_i = 1'b0;
        if (tmo) begin
            data_rvalid_i = 1'b1;
            data_rdata_i  = rdata;
        end
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        check("wb_pulse", wb_valid_o, 0);
        check("err_pulse", lsu_bus_err_o, 0);
        check("idle_req", data_req_o, 0);
        check("idle_stall", lsu_stall_o, 0);
    endtask

    initial begin
        logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic        we;
        logic [2:0]  f3;
        repeat (3) @(negedge clk_i);
        check("rst_stall", lsu_stall_o, 0);
        check("rst_req", data_req_o, 0);
        check("rst_wbv", wb_valid_o, 0);
        check("rst_addr", data_addr_o, 0);
        check("rst_wbdata", wb_data_o, 0);
        rst_i = 1'b0;

        do_op(1'b0, 3'd2, 32'h100, 32'h0, 5'd5, 0, 0, 32'hDEAD_BEEF);
        do_op(1'b0, 3'd0, 32'h103, 32'h0, 5'd1, 0, 0, 32'h80FF_FF7F);
        do_op(1'b0, 3'd4, 32'h103, 32'h0, 5'd2, 0, 1, 32'h80FF_FF7F);
        do_op(1'b0, 3'd1, 32'h102, 32'h0, 5'd3, 1, 0, 32'h80FF_FF7F);
        do_op(1'b0, 3'd5, 32'h100, 32'h0, 5'd4, 0, 2, 32'h80FF_FF7F);
        do_op(1'b1, 3'd0, 32'h201, 32'h1234_5678, 5'd0, 0, 0, 32'h0);
        do_op(1'b1, 3'd1, 32'h202, 32'h1234_5678, 5'd0, 0, 0, 32'h0);
        do_op(1'b1, 3'd1, 32'h101, 32'h1234_5678, 5'd0, 0, 0, 32'h0);
        do_op(1'b0, 3'd2, 32'h102, 32'h0, 5'd6, 0, 0, 32'h0);
        do_op(1'b0, 3'd2, 32'h300, 32'h0, 5'd7, 3, 1, 32'hCAFE_F00D);
        do_op(1'b0, 3'd2, 32'h304, 32'h0, 5'd8, 0, TO + 2, 32'h1111_2222);
        do_op(1'b1, 3'd2, 32'h308, 32'hA5A5_5A5A, 5'd0, 2, TO, 32'h0);

        // Reset while waiting for the response.
        @(negedge clk_i);
        lsu_valid_i = 1'b1; lsu_we_i = 1'b0; lsu_funct3_i = 3'd2;
        lsu_addr_i = 32'h100; lsu_rd_addr_i = 5'd9;
        @(negedge clk_i);
        data_gnt_i = 1'b1;
        @(negedge clk_i);
        data_gnt_i = 1'b0;
        check("pre_rst_stall", lsu_stall_o, 1);
        #1 rst_i = 1'b1;
        #1;
        check("arst_stall", lsu_stall_o, 0);
        check("arst_req", data_req_o, 0);
        check("arst_addr", data_addr_o, 0);
        check("arst_be", data_be_o, 0);
        check("arst_wbv", wb_valid_o, 0);
        check("arst_err", lsu_bus_err_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        lsu_valid_i = 1'b0;
        data_rvalid_i = 1'b1;
        data_rdata_i = 32'h1234_5678;
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        check("stray_wbv", wb_valid_o, 0);
        check("stray_err", lsu_bus_err_o, 0);
        check("stray_stall", lsu_stall_o, 0);
        check("stray_req", data_req_o, 0);

        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = we ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
            do_op(we, f3, $urandom, $urandom, 5'($urandom), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, TO + 1)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
